// File: rtl/audio_sequence_player.sv
// ---------------------------------------------------------------------------
// audio_sequence_player
//
// Plays one stored note sequence as a square wave. The notes come from an
// external synchronous ROM that has a 1-cycle read latency. Each ROM entry is
// a (half-period, duration) pair. When the sequence completes normally, the
// block emits a 1-cycle seqEnd pulse that feeds the sequence-end mux.
//
// Ports:
//   clk       in   1      system clock, rising edge
//   rst_n     in   1      synchronous active-low reset
//   start     in   1      begin playback (sampled only in IDLE)
//   abort     in   1      stop playback immediately (wins over start)
//   noteAddr  out  AW     registered ROM address
//   noteHalf  in   DIV_W  ROM data: tone half-period in cycles, 0 = rest
//   noteDur   in   DUR_W  ROM data: note length in cycles, 0 = end marker
//   audioOut  out  1      registered square-wave output
//   busy      out  1      high in FETCH, LOAD and PLAY
//   seqEnd    out  1      1-cycle pulse on normal completion
// ---------------------------------------------------------------------------
module audio_sequence_player #(
    parameter  int SEQ_LEN = 8,
    parameter  int DIV_W   = 18,
    parameter  int DUR_W   = 24,
    localparam int AW      = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [AW-1:0]    noteAddr,
    input  logic [DIV_W-1:0] noteHalf,
    input  logic [DUR_W-1:0] noteDur,
    output logic             audioOut,
    output logic             busy,
    output logic             seqEnd
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        PLAY  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(SEQ_LEN - 1);

    state_t            state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic              audio_q, audio_d;
    logic [DIV_W-1:0]  half_q, half_d;
    logic [DIV_W-1:0]  tone_cnt_q, tone_cnt_d;
    logic [DUR_W-1:0]  dur_cnt_q, dur_cnt_d;

    // State and datapath registers. Everything returns to the idle values on
    // reset, so no stale note can leak into the next playback.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            audio_q    <= 1'b0;
            half_q     <= '0;
            tone_cnt_q <= '0;
            dur_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            audio_q    <= audio_d;
            half_q     <= half_d;
            tone_cnt_q <= tone_cnt_d;
            dur_cnt_q  <= dur_cnt_d;
        end
    end

    // Next-state logic. Abort wins in every state. In IDLE it also blocks a
    // simultaneous start. The last ROM slot ends the sequence even if it does
    // not hold an end marker, so the address never wraps.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = FETCH;
                FETCH:   state_d = LOAD;
                LOAD:    state_d = (noteDur == '0) ? DONE : PLAY;
                PLAY: begin
                    if (dur_cnt_q == '0) begin
                        state_d = (addr_q == LAST_ADDR) ? DONE : FETCH;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath. durCnt is loaded with noteDur-1, so a note spends exactly
    // noteDur cycles in PLAY. The tone counter wraps on the same cycle the
    // output toggles, which makes the period 2*noteHalf cycles. Any state
    // other than PLAY forces the output low, so every note starts low.
    always_comb begin
        addr_d     = addr_q;
        half_d     = half_q;
        tone_cnt_d = tone_cnt_q;
        dur_cnt_d  = dur_cnt_q;
        audio_d    = 1'b0;
        case (state_q)
            IDLE, DONE: addr_d = '0;
            LOAD: begin
                half_d     = noteHalf;
                dur_cnt_d  = noteDur - DUR_W'(1);
                tone_cnt_d = '0;
            end
            PLAY: begin
                dur_cnt_d = dur_cnt_q - DUR_W'(1);
                if (half_q != '0) begin
                    if (tone_cnt_q == half_q - DIV_W'(1)) begin
                        tone_cnt_d = '0;
                        audio_d    = ~audio_q;
                    end else begin
                        tone_cnt_d = tone_cnt_q + DIV_W'(1);
                        audio_d    = audio_q;
                    end
                end
                if (dur_cnt_q == '0 && addr_q != LAST_ADDR) begin
                    addr_d = addr_q + AW'(1);
                end
            end
            default: ;
        endcase
        if (abort) begin
            addr_d = '0;
        end
        if (state_d != PLAY) begin
            audio_d = 1'b0;
        end
    end

    // Outputs. seqEnd is qualified with abort so that an abort arriving in
    // DONE suppresses the pulse in that same cycle.
    always_comb begin
        busy     = (state_q == FETCH) || (state_q == LOAD) || (state_q == PLAY);
        seqEnd   = (state_q == DONE) && !abort;
        noteAddr = addr_q;
        audioOut = audio_q;
    end

endmodule
